timer_setup_ctrl: RTL and testbench
===================================

Name: timer_setup_ctrl

Overview:
Control and sequencing block for the countdown timer datapath.
- Conditions the four raw push buttons.
- Owns the run/stop state and drives the divider work enable.
- Walks the operator through setting seconds, minutes and hours, then issues a single load pulse with the composed value.
- Detects expiry and drives the alarm LEDs.
- Sits between the board buttons/mode selector and the sec/min/hour counter chain.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized button must be stable before its debounced level changes (10 ms at 50 MHz)
ALARM_CYCLES, 250000000, cycles ALARM is held before auto-return to STOP (5 s)
SEC_MAX, 59, wrap limit for the seconds and minutes fields
HOUR_MAX, 23, wrap limit for the hours field

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
rezhim  in  2  display mode; button presses are accepted only when rezhim == 1
button  in  4  raw active-high buttons: [3]=start/stop, [2]=set/next, [1]=increment, [0]=clear
data_t  in  24  live counter value {hour[23:16], min[15:8], sec[7:0]}, binary
run_en  out  1  work enable for the clock divider
setup_imp  out  1  one-cycle load strobe for all counters
setup_data  out  24  value loaded on setup_imp, same packing as data_t
field_sel  out  2  field being edited: 0=none, 1=sec, 2=min, 3=hour
alarm  out  1  high while in ALARM
led  out  4  4'hF in ALARM, else 4'h0

Behaviour:
- One clock. Reset is synchronous and active-high. All flops update on posedge clock only; nothing is clocked by a button.
- Reset values: run_en=0, setup_imp=0, setup_data=0, field_sel=0, alarm=0, led=0, state=STOP, debounced levels=0, all counters=0.
- Button conditioning, per bit:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level changes after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized level.
  - A press is a one-cycle pulse on the debounced 0->1 transition. Release generates nothing.
  - Presses are discarded (not queued) when rezhim != 1.
- Same-cycle press priority: start > set > clear > inc. Only the highest-priority press acts; the others are dropped.
- zero = (data_t == 0).
- STOP: run_en=0.
  - start and !zero -> RUN.
  - start and zero -> stay in STOP.
  - set -> SET_SEC; setup_data <= data_t in the same cycle.
  - clear -> setup_data <= 0 and setup_imp pulses the next cycle.
- RUN: run_en=1.
  - start -> STOP.
  - zero -> ALARM; run_en drops the cycle after zero is seen.
  - set, clear and inc are ignored.
  - Expiry is detected even when rezhim != 1.
- SET_SEC / SET_MIN / SET_HOUR: field_sel = 1 / 2 / 3, run_en=0.
  - inc: field <= (field >= limit) ? 0 : field + 1. Limit is SEC_MAX for sec/min and HOUR_MAX for hour. Out-of-range captured values therefore wrap to 0.
  - clear: current field <= 0.
  - set: SET_SEC->SET_MIN, SET_MIN->SET_HOUR.
  - set in SET_HOUR: setup_imp=1 for exactly one cycle with setup_data stable, then -> STOP, field_sel=0.
  - start: abort -> STOP with no setup_imp. setup_data keeps its edited value but is not loaded.
- ALARM: alarm=1, led=4'hF, run_en=0.
  - Any accepted press, or ALARM_CYCLES elapsed (counter starts on entry), -> STOP with alarm=0 and led=0 the next cycle.
- setup_data changes only in SET_*, on capture, or on clear in STOP. It is held otherwise.
- setup_imp never asserts in RUN or ALARM.
- Reset mid-edit or mid-alarm returns to STOP with no setup_imp emitted.

Optional Feature:
TIMER_AUTOREPEAT_EN
- Defined: while increment stays debounced-high in a SET_* state, an extra inc is generated after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles. These parameters (default 25000000 / 5000000) exist only under the macro.
- The repeat counter resets on release and on any state change.
- Undefined: one increment per press only; no repeat logic or parameters.

Test Plan (DEBOUNCE_CYCLES=4, ALARM_CYCLES=20 in bench):
1. reset high 2 cycles -> all outputs 0, field_sel=0. Hold button[3] 1 cycle with 1-cycle glitches -> no state change.
2. rezhim=1, data_t=24'h00_01_05, press start -> run_en=1 exactly 2+4 cycles after the clean edge. Press start again -> run_en=0.
3. RUN, drive data_t to 0 -> alarm=1, led=4'hF, run_en=0. No press -> alarm clears after 20 cycles. Repeat, press clear at cycle 5 -> STOP immediately.
4. STOP, data_t=24'h00_00_3A:
   - set -> field_sel=1.
   - inc twice -> setup_data[7:0]=0x3B, then 0x00 (wrap at 59).
   - set -> field_sel=2.
   - set -> field_sel=3.
   - inc 24 times from 23 -> hour wraps to 0 then increments.
   - set -> single-cycle setup_imp, field_sel=0.
5. SET_MIN, press start and inc in the same cycle -> STOP, no setup_imp, no increment. Set rezhim=2 and press set -> nothing happens.
6. STOP, data_t=0, press start -> stays STOP, run_en=0. Press clear -> setup_data=0, setup_imp one cycle.

Source files
------------

// File: rtl/timer_setup_ctrl.sv
// timer_setup_ctrl
//   Control and sequencing block for the countdown timer datapath.
//   - Conditions the four raw push buttons: 2-flop synchronizer plus a
//     stability counter per bit. A press is a one-cycle pulse on the
//     debounced rising edge.
//   - Owns the run/stop state and drives the divider work enable.
//   - Walks the operator through editing seconds, minutes and hours, then
//     emits a single load strobe carrying the composed value.
//   - Detects expiry and drives the alarm LEDs.
//
// Ports
//   clock       in   system clock
//   reset       in   synchronous, active-high reset
//   rezhim[1:0] in   display mode; presses are accepted only when rezhim == 1
//   button[3:0] in   raw buttons: [3]=start/stop [2]=set/next [1]=inc [0]=clear
//   data_t[23:0] in  live counter value {hour, min, sec}, binary
//   run_en      out  work enable for the clock divider
//   setup_imp   out  one-cycle load strobe for all counters
//   setup_data  out  value loaded on setup_imp, packed like data_t
//   field_sel   out  field being edited: 0=none 1=sec 2=min 3=hour
//   alarm       out  high while in ALARM
//   led[3:0]    out  4'hF in ALARM, else 4'h0
//
// Optional build macro: TIMER_AUTOREPEAT_EN
//   When defined, holding increment in an edit state generates an extra
//   increment after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module timer_setup_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ALARM_CYCLES    = 250000000,
  parameter int SEC_MAX         = 59,
  parameter int HOUR_MAX        = 23
`ifdef TIMER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  rezhim,
  input  logic [3:0]  button,
  input  logic [23:0] data_t,
  output logic        run_en,
  output logic        setup_imp,
  output logic [23:0] setup_data,
  output logic [1:0]  field_sel,
  output logic        alarm,
  output logic [3:0]  led
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ALM_W = (ALARM_CYCLES > 2) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_CYCLES - 1);
  localparam logic [7:0]       SEC_LIM  = 8'(SEC_MAX);
  localparam logic [7:0]       HOUR_LIM = 8'(HOUR_MAX);

  typedef enum logic [2:0] {
    ST_STOP, ST_RUN, ST_SET_SEC, ST_SET_MIN, ST_SET_HOUR, ST_ALARM
  } state_t;

  state_t state;

  // Field increment with wrap; values already above the limit wrap to 0.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? 8'd0 : v + 8'd1;
  endfunction

  // Stage p0/p1: button synchronizer, then debounce level and stability count
  logic [3:0]       btn_p0, btn_p1;
  logic [3:0]       deb;
  logic [DEB_W-1:0] deb_cnt [4];
  logic [3:0]       rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      deb    <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      btn_p0 <= button;
      btn_p1 <= btn_p0;
      for (int i = 0; i < 4; i++) begin
        if (btn_p1[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= btn_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // The press pulse is raised in the cycle the debounced level commits to 1,
  // so the FSM acts on the same edge that updates deb.
  always_comb begin
    for (int i = 0; i < 4; i++)
      rise[i] = btn_p1[i] & ~deb[i] & (deb_cnt[i] == DEB_LAST);
  end

  logic [3:0] acc;
  logic       p_start, p_set, p_clr, p_inc, any_press, inc_evt, zero;

  assign acc       = rise & {4{rezhim == 2'd1}};
  assign p_start   = acc[3];
  assign p_set     = acc[2] & ~acc[3];
  assign p_clr     = acc[0] & ~acc[3] & ~acc[2];
  assign p_inc     = acc[1] & ~acc[3] & ~acc[2] & ~acc[0];
  assign any_press = |acc;
  assign zero      = (data_t == 24'd0);

`ifdef TIMER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  state_t           state_q;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed, in_set, rpt_hold, rpt_fire;

  assign in_set   = (state == ST_SET_SEC) || (state == ST_SET_MIN) || (state == ST_SET_HOUR);
  assign rpt_hold = in_set & deb[1] & (state == state_q);
  assign rpt_fire = rpt_hold & (rpt_cnt == (rpt_armed ? RPT_PER_LAST : RPT_DLY_LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_STOP;
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else begin
      state_q <= state;
      if (!rpt_hold) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  // Repeats obey the same mode gating and lose to any real higher press.
  assign inc_evt = p_inc | (rpt_fire & (rezhim == 2'd1) & ~acc[3] & ~acc[2] & ~acc[0]);
`else
  assign inc_evt = p_inc;
`endif

  // Stage p2: sequencing FSM with registered outputs
  logic [ALM_W-1:0] alarm_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_STOP;
      run_en     <= 1'b0;
      setup_imp  <= 1'b0;
      setup_data <= '0;
      field_sel  <= 2'd0;
      alarm      <= 1'b0;
      led        <= 4'h0;
      alarm_cnt  <= '0;
    end else begin
      setup_imp <= 1'b0;
      case (state)
        ST_STOP: begin
          run_en    <= 1'b0;
          field_sel <= 2'd0;
          alarm     <= 1'b0;
          led       <= 4'h0;
          if (p_start) begin
            if (!zero) begin
              state  <= ST_RUN;
              run_en <= 1'b1;
            end
          end else if (p_set) begin
            state      <= ST_SET_SEC;
            field_sel  <= 2'd1;
            setup_data <= data_t;
          end else if (p_clr) begin
            setup_data <= '0;
            setup_imp  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (p_start) begin
            state  <= ST_STOP;
            run_en <= 1'b0;
          end else if (zero) begin
            state     <= ST_ALARM;
            run_en    <= 1'b0;
            alarm     <= 1'b1;
            led       <= 4'hF;
            alarm_cnt <= '0;
          end
        end
        ST_SET_SEC: begin
          if (p_start) begin
            state     <= ST_STOP;
            field_sel <= 2'd0;
          end else if (p_set) begin
            state     <= ST_SET_MIN;
            field_sel <= 2'd2;
          end else if (p_clr) begin
            setup_data[7:0] <= 8'd0;
          end else if (inc_evt) begin
            setup_data[7:0] <= wrap_inc(setup_data[7:0], SEC_LIM);
          end
        end
        ST_SET_MIN: begin
          if (p_start) begin
            state     <= ST_STOP;
            field_sel <= 2'd0;
          end else if (p_set) begin
            state     <= ST_SET_HOUR;
            field_sel <= 2'd3;
          end else if (p_clr) begin
            setup_data[15:8] <= 8'd0;
          end else if (inc_evt) begin
            setup_data[15:8] <= wrap_inc(setup_data[15:8], SEC_LIM);
          end
        end
        ST_SET_HOUR: begin
          if (p_start) begin
            state     <= ST_STOP;
            field_sel <= 2'd0;
          end else if (p_set) begin
            state     <= ST_STOP;
            field_sel <= 2'd0;
            setup_imp <= 1'b1;
          end else if (p_clr) begin
            setup_data[23:16] <= 8'd0;
          end else if (inc_evt) begin
            setup_data[23:16] <= wrap_inc(setup_data[23:16], HOUR_LIM);
          end
        end
        ST_ALARM: begin
          if (any_press || (alarm_cnt == ALM_LAST)) begin
            state <= ST_STOP;
            alarm <= 1'b0;
            led   <= 4'h0;
          end else begin
            alarm_cnt <= alarm_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_STOP;
          run_en    <= 1'b0;
          field_sel <= 2'd0;
          alarm     <= 1'b0;
          led       <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_setup_ctrl.sv
module tb_timer_setup_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  rezhim;
  logic [3:0]  button;
  logic [23:0] data_t;
  logic        run_en, setup_imp, alarm;
  logic [23:0] setup_data;
  logic [1:0]  field_sel;
  logic [3:0]  led;

  int total = 0;
  int bad   = 0;
  int imp_cnt = 0;

  timer_setup_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ALARM_CYCLES(20),
    .SEC_MAX(59),
    .HOUR_MAX(23)
  ) dut (
    .clock(clock), .reset(reset), .rezhim(rezhim), .button(button),
    .data_t(data_t), .run_en(run_en), .setup_imp(setup_imp),
    .setup_data(setup_data), .field_sel(field_sel), .alarm(alarm), .led(led)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (setup_imp) imp_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Press acts on the 6th edge after the button rises; hold and release fully.
  task automatic press(input logic [3:0] m);
    button = m;
    tick(8);
    button = 4'h0;
    tick(8);
  endtask

  task automatic test_reset;
    reset = 1'b1; rezhim = 2'd1; button = 4'h0; data_t = 24'h000105;
    tick(2);
    total++;
    if ({run_en, setup_imp, alarm, led, field_sel, setup_data} !== 33'd0) begin
      bad++;
      $display("FAIL reset_outputs got run=%b imp=%b alarm=%b led=%h fsel=%0d sd=%h exp all 0",
               run_en, setup_imp, alarm, led, field_sel, setup_data);
    end
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      button = 4'h8; tick(1);
      button = 4'h0; tick(1);
    end
    tick(10);
    total++;
    if (run_en !== 1'b0) begin
      bad++; $display("FAIL glitch_ignored run_en=%b exp=0", run_en);
    end
  endtask

  task automatic test_start_stop;
    data_t = 24'h000105; rezhim = 2'd1;
    button = 4'h8;
    tick(5);
    total++;
    if (run_en !== 1'b0) begin
      bad++; $display("FAIL start_early run_en=%b exp=0", run_en);
    end
    tick(1);
    total++;
    if (run_en !== 1'b1) begin
      bad++; $display("FAIL start_latency run_en=%b exp=1", run_en);
    end
    tick(2); button = 4'h0; tick(8);
    press(4'h8);
    total++;
    if (run_en !== 1'b0) begin
      bad++; $display("FAIL stop run_en=%b exp=0", run_en);
    end
  endtask

  task automatic test_alarm;
    data_t = 24'h000105;
    press(4'h8);
    data_t = 24'h000000;
    tick(1);
    total++;
    if (alarm !== 1'b1 || led !== 4'hF || run_en !== 1'b0) begin
      bad++; $display("FAIL alarm_entry alarm=%b led=%h run=%b exp 1/F/0", alarm, led, run_en);
    end
    tick(19);
    total++;
    if (alarm !== 1'b1) begin
      bad++; $display("FAIL alarm_hold alarm=%b exp=1", alarm);
    end
    tick(1);
    total++;
    if (alarm !== 1'b0 || led !== 4'h0) begin
      bad++; $display("FAIL alarm_timeout alarm=%b led=%h exp 0/0", alarm, led);
    end
    data_t = 24'h000105;
    press(4'h8);
    data_t = 24'h000000;
    tick(1);
    tick(4);
    button = 4'h1;
    tick(5);
    total++;
    if (alarm !== 1'b1) begin
      bad++; $display("FAIL alarm_before_clear alarm=%b exp=1", alarm);
    end
    tick(1);
    total++;
    if (alarm !== 1'b0 || led !== 4'h0 || run_en !== 1'b0) begin
      bad++; $display("FAIL alarm_clear alarm=%b led=%h run=%b exp 0/0/0", alarm, led, run_en);
    end
    tick(2); button = 4'h0; tick(8);
  endtask

  task automatic test_edit;
    data_t = 24'h00003A;
    imp_cnt = 0;
    press(4'h4);
    total++;
    if (field_sel !== 2'd1 || setup_data !== 24'h00003A) begin
      bad++; $display("FAIL edit_capture fsel=%0d sd=%h exp 1/00003a", field_sel, setup_data);
    end
    press(4'h2);
    total++;
    if (setup_data[7:0] !== 8'h3B) begin
      bad++; $display("FAIL sec_inc sec=%h exp=3b", setup_data[7:0]);
    end
    press(4'h2);
    total++;
    if (setup_data[7:0] !== 8'h00) begin
      bad++; $display("FAIL sec_wrap sec=%h exp=00", setup_data[7:0]);
    end
    press(4'h4);
    total++;
    if (field_sel !== 2'd2) begin
      bad++; $display("FAIL to_min fsel=%0d exp=2", field_sel);
    end
    press(4'h4);
    total++;
    if (field_sel !== 2'd3) begin
      bad++; $display("FAIL to_hour fsel=%0d exp=3", field_sel);
    end
    for (int i = 0; i < 23; i++) press(4'h2);
    total++;
    if (setup_data[23:16] !== 8'd23) begin
      bad++; $display("FAIL hour_23 hour=%0d exp=23", setup_data[23:16]);
    end
    press(4'h2);
    total++;
    if (setup_data[23:16] !== 8'd0) begin
      bad++; $display("FAIL hour_wrap hour=%0d exp=0", setup_data[23:16]);
    end
    press(4'h2);
    total++;
    if (imp_cnt !== 0) begin
      bad++; $display("FAIL no_imp_in_edit imp_cnt=%0d exp=0", imp_cnt);
    end
    press(4'h4);
    total++;
    if (imp_cnt !== 1 || field_sel !== 2'd0 || setup_data !== 24'h010000) begin
      bad++; $display("FAIL load imp_cnt=%0d fsel=%0d sd=%h exp 1/0/010000", imp_cnt, field_sel, setup_data);
    end
  endtask

  task automatic test_abort_and_mode;
    data_t = 24'h00003A;
    imp_cnt = 0;
    press(4'h4);
    press(4'h4);
    total++;
    if (field_sel !== 2'd2) begin
      bad++; $display("FAIL abort_setup fsel=%0d exp=2", field_sel);
    end
    press(4'hA);
    total++;
    if (field_sel !== 2'd0 || imp_cnt !== 0 || setup_data !== 24'h00003A || run_en !== 1'b0) begin
      bad++; $display("FAIL abort fsel=%0d imp=%0d sd=%h run=%b exp 0/0/00003a/0",
                      field_sel, imp_cnt, setup_data, run_en);
    end
    rezhim = 2'd2;
    press(4'h4);
    total++;
    if (field_sel !== 2'd0 || setup_data !== 24'h00003A) begin
      bad++; $display("FAIL mode_gate fsel=%0d sd=%h exp 0/00003a", field_sel, setup_data);
    end
    rezhim = 2'd1;
  endtask

  task automatic test_zero_start_clear;
    data_t = 24'h000000;
    imp_cnt = 0;
    press(4'h8);
    total++;
    if (run_en !== 1'b0 || alarm !== 1'b0) begin
      bad++; $display("FAIL zero_start run=%b alarm=%b exp 0/0", run_en, alarm);
    end
    press(4'h1);
    total++;
    if (setup_data !== 24'h0 || imp_cnt !== 1) begin
      bad++; $display("FAIL clear_load sd=%h imp_cnt=%0d exp 000000/1", setup_data, imp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_alarm();
    test_edit();
    test_abort_and_mode();
    test_zero_start_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
